// File: rtl/u_rcv.sv
// u_rcv: UART receiver for a 16x-oversampled line. Recovers start / WORD_LEN
// data bits (LSB first) / one stop bit and hands the word over through a
// ready/acknowledge handshake, flagging framing and overrun errors.
module u_rcv #(
  parameter int WORD_LEN = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst_l,
  input  logic                uart_dataH,
  input  logic                rec_ackH,
  output logic [WORD_LEN-1:0] rec_dataH,
  output logic                rec_readyH,
  output logic                rec_busyH,
  output logic                frame_errH,
  output logic                overrun_errH
);

  typedef enum logic [2:0] {
    r_IDLE  = 3'd0,
    r_START = 3'd1,
    r_DATA  = 3'd2,
    r_STOP  = 3'd3,
    r_BREAK = 3'd4
  } state_t;

  localparam int             BCW      = $clog2(WORD_LEN + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_LEN - 1);
  localparam logic [3:0]     MID_CELL = 4'd7;
  localparam logic [3:0]     END_CELL = 4'd15;

  state_t              state;
  state_t              state_next;
  logic                sync_1;
  logic                rx_s;
  logic [3:0]          cnt;
  logic [BCW-1:0]      bit_cnt;
  logic [WORD_LEN-1:0] shift_reg;
  logic [WORD_LEN-1:0] shift_next;
  logic                sample_bit;
  logic                good_stop;
  logic                bad_stop;

  // Two-flop synchronizer for the asynchronous line; idles (and resets) high.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    if (!sys_rst_l) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= uart_dataH;
      rx_s   <= sync_1;
    end
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) state <= r_IDLE;
    else            state <= state_next;
  end

  // Next-state logic; unused encodings fall back to idle.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_next
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    case (state)
      r_IDLE:  if (!rx_s) state_next = r_START;
      r_START: if (cnt == MID_CELL) state_next = rx_s ? r_IDLE : r_DATA;
      r_DATA:  if (cnt == END_CELL && bit_cnt == LAST_BIT) state_next = r_STOP;
      r_STOP:  if (cnt == END_CELL) state_next = rx_s ? r_IDLE : r_BREAK;
      r_BREAK: if (rx_s) state_next = r_IDLE;
      default: state_next = r_IDLE;
    endcase
  end

  // Output decode: sampling strobes for the datapath and handshake.
  always_comb begin
    sample_bit = (state == r_DATA) && (cnt == END_CELL);
    good_stop  = (state == r_STOP) && (cnt == END_CELL) && rx_s;
    bad_stop   = (state == r_STOP) && (cnt == END_CELL) && !rx_s;
    shift_next = shift_reg >> 1;
    shift_next[WORD_LEN-1] = rx_s;
  end

  // Bit-cell counter restarts on every state change; bit counter tracks data bits.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      cnt       <= 4'd0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      cnt <= (state_next != state) ? 4'd0 : cnt + 4'd1;
      if (state != r_DATA) bit_cnt <= '0;
      else if (sample_bit) bit_cnt <= bit_cnt + BCW'(1);
      // Right shift with the new bit entering at the MSB leaves the first
      // (least significant) bit at position 0 after WORD_LEN samples.
      if (sample_bit) shift_reg <= shift_next;
    end
  end

  // Handshake, error pulses and registered busy decode.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      rec_dataH    <= '0;
      rec_readyH   <= 1'b0;
      rec_busyH    <= 1'b0;
      frame_errH   <= 1'b0;
      overrun_errH <= 1'b0;
    end else begin
      frame_errH   <= bad_stop;
      // An acknowledge on the same edge as a new word consumes the old one,
      // so only an unacknowledged pending word counts as overrun.
      overrun_errH <= good_stop && rec_readyH && !rec_ackH;
      if (good_stop) begin
        rec_dataH  <= shift_reg;
        rec_readyH <= 1'b1;
      end else if (rec_ackH) begin
        rec_readyH <= 1'b0;
      end
      rec_busyH <= (state_next != r_IDLE);
    end
  end

endmodule
